bictr_timer_sched: RTL and testbench
====================================

Name: bictr_timer_sched

Overview:
- Shares one up/down counter with dynamic terminal count between NUM_REQ requesters. Each requester asks for one timed interval.
- The block arbitrates round-robin, programs the counter (start value, terminal value, direction), runs it to terminal count and pulses a per-requester done.
- It sits between software-visible timer request logic and the counter datapath. The counter is embedded as a sub-module.

Parameters:
- width, 8, counter and interval-length width in bits.
- NUM_REQ, 4, number of requesters (2..16).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per requester; held high until its done pulse.
- req_len  input  NUM_REQ*width  interval length per requester; slice i = bits [i*width +: width].
- req_dir  input  NUM_REQ  per-requester direction; 1 = count up, 0 = count down.
- pause  input  1  freezes counting while high (RUN state only).
- abort  input  1  cancels the current interval without a done pulse.
- gnt  output  NUM_REQ  one-hot grant; high from LOAD through DONE.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- busy  output  1  high in LOAD, RUN and DONE.
- count  output  width  live counter value.
- tercnt  output  1  counter at terminal value (count == programmed count_to).

Behaviour:
- Reset values: state IDLE, round-robin pointer 0, gnt/done/busy 0, counter count 0, latched len/dir/index 0. tercnt follows count == latched count_to (0) and therefore reads 1 after reset.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick the first requester at or after the round-robin pointer (wrapping).
  - Latch its index, req_len slice and req_dir. Go to LOAD.
  - The pointer becomes winner+1 mod NUM_REQ on each grant.
- LOAD (1 cycle):
  - Assert counter load.
  - Direction up: data = 0, count_to = len.
  - Direction down: data = len, count_to = 0.
  - Go to RUN.
- RUN:
  - If tercnt: go to DONE.
  - Otherwise cen = ~pause, and the counter steps ±1 per enabled cycle.
- DONE (1 cycle): done[idx] = 1. Go to IDLE.
- Latency with no pause: req seen in IDLE at cycle 0 -> LOAD at 1 -> RUN from 2 -> done high at cycle len+3.
  - len = 0 gives done at cycle 3.
  - Each pause cycle in RUN adds one cycle.
- Back-to-back: after DONE, the block spends one IDLE cycle before the next grant.
  - A requester still holding req after its done competes again with lowest priority.
- req or req_len changes after the grant are ignored; the interval uses latched values.
- Deasserting req mid-interval does not cancel; only abort does.
- abort:
  - In LOAD or RUN: next state IDLE, gnt cleared, no done pulse, pointer keeps its post-grant value.
  - Ignored in IDLE and DONE.
  - abort and tercnt in the same RUN cycle: abort wins, no done.
- pause and tercnt in the same cycle: tercnt wins (go to DONE).
- Reset mid-operation: immediately returns everything to reset values; no done pulse.
- Counter arithmetic:
  - Modulo 2^width; load has priority over cen.
  - The sequencer never lets the counter wrap, because it stops at tercnt. Wrap behaviour is still defined for the sub-module.
- gnt and done are always one-hot or zero, never multi-hot.

Decomposition:
- Package bictr_sched_pkg:
  - state enum {IDLE, LOAD, RUN, DONE};
  - localparam IDX_W = clog2(NUM_REQ) (minimum 1);
  - DIR_UP = 1, DIR_DN = 0 constants.
- Sub-module bictr_dcnto_core:
  - parameter width; ports clk, reset, data, count_to, up_dn, load, cen, count, tercnt.
  - Synchronous reset to 0; tercnt combinational.
- Round-robin selection stays inline in the top module.

Test Plan:
- Single up request: width=8, req[0]=1, len=5, dir=1 at cycle 0 -> gnt=0001 from cycle 1; count 0,1..5 in cycles 2..7; done=0001 in cycle 8; busy low at 9.
- Down request with len=0: req[2], dir=0 -> count=0 and tercnt=1 in cycle 2; done=0100 in cycle 3.
- Round-robin, all four req held high, len=1:
  - Grants 0,1,2,3,0 in order, each done 4 cycles after its grant (len+3 = 4 cycles from the IDLE decision).
  - One IDLE cycle separates consecutive intervals.
- Pause: req[1], len=3, up; pause high for 2 cycles while count=1 -> count holds 1 for those cycles; done delayed by 2 cycles to cycle 8.
- Abort:
  - req[3], len=10, abort in the cycle where count=4 -> next cycle IDLE, gnt=0, no done.
  - req[0] pending is granted in the following cycle.
  - abort coincident with tercnt -> no done.
- Reset mid-RUN at count=3 -> next cycle count=0, gnt=0, busy=0, pointer=0; a later req[2] is granted normally.

Source files
------------

// File: rtl/bictr_sched_pkg.sv
// Shared types and constants for the shared-counter interval scheduler.
package bictr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Requester-index width; a single requester bit is never narrower than 1.
  function automatic int calc_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bictr_dcnto_core.sv
// Up/down counter with load, enable and a dynamic terminal-count compare.
module bictr_dcnto_core #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic [width-1:0] count_to,
  input  logic             up_dn,
  input  logic             load,
  input  logic             cen,
  output logic [width-1:0] count,
  output logic             tercnt
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  // Load has priority over enable; arithmetic wraps modulo 2^width.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data;
    end else if (cen) begin
      count_d = up_dn ? (count_q + width'(1)) : (count_q - width'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign tercnt = (count_q == count_to);

endmodule

// File: rtl/bictr_timer_sched.sv
// Round-robin scheduler sharing one up/down interval counter between requesters.
//   state | meaning
//   IDLE  | no interval active; arbitrate among pending requests
//   LOAD  | program counter start value from the latched length/direction
//   RUN   | count toward the terminal value (pause freezes, abort cancels)
//   DONE  | one-cycle completion pulse to the granted requester
module bictr_timer_sched
  import bictr_sched_pkg::*;
#(
  parameter int width   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*width-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic                     pause,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [width-1:0]         count,
  output logic                     tercnt
);

  localparam int IDX_W = calc_idx_w(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [width-1:0]   len_q, len_d;
  logic               dir_q, dir_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;

  logic               hi_found;
  logic [IDX_W-1:0]   hi_win;
  logic [IDX_W-1:0]   lo_win;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [width-1:0]   len_sel;
  logic               dir_sel;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] idx_oh;

  logic [width-1:0]   cnt_data;
  logic [width-1:0]   cnt_to;
  logic               cnt_load;
  logic               cnt_cen;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (IDX_W'(j) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_win   = IDX_W'(j);
      end
      if (req[j]) begin
        lo_win = IDX_W'(j);
      end
    end
    win     = hi_found ? hi_win : lo_win;
    ptr_nxt = (win == IDX_W'(NUM_REQ - 1)) ? '0 : (win + IDX_W'(1));
  end

  always_comb begin
    len_sel = '0;
    dir_sel = 1'b0;
    win_oh  = '0;
    idx_oh  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == IDX_W'(j)) begin
        len_sel   = req_len[j*width +: width];
        dir_sel   = req_dir[j];
        win_oh[j] = 1'b1;
      end
      if (idx_q == IDX_W'(j)) begin
        idx_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dir_d   = dir_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOAD;
          idx_d   = win;
          len_d   = len_sel;
          dir_d   = dir_sel;
          ptr_d   = ptr_nxt;
          gnt_d   = win_oh;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // abort outranks terminal count, which outranks pause
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (tercnt) begin
          state_d = DONE;
          done_d  = idx_oh;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      dir_q   <= DIR_DN;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Up intervals run 0 -> len, down intervals run len -> 0.
  assign cnt_data = (dir_q == DIR_DN) ? len_q : '0;
  assign cnt_to   = (dir_q == DIR_UP) ? len_q : '0;
  assign cnt_load = (state_q == LOAD);
  assign cnt_cen  = (state_q == RUN) && !tercnt && !pause;

  bictr_dcnto_core #(
    .width(width)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .data    (cnt_data),
    .count_to(cnt_to),
    .up_dn   (dir_q),
    .load    (cnt_load),
    .cen     (cnt_cen),
    .count   (count),
    .tercnt  (tercnt)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bictr_timer_sched.sv
// Scoreboard bench: stimulus queues expected done pulses, a monitor checks them.
module tb_bictr_timer_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_len;
  logic [N-1:0]   req_dir;
  logic           pause;
  logic           abort;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;
  logic           tercnt;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int t0;
  int t1;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t sb[$];

  bictr_timer_sched #(.width(W), .NUM_REQ(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .req_len(req_len),
    .req_dir(req_dir),
    .pause  (pause),
    .abort  (abort),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .count  (count),
    .tercnt (tercnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic expect_done(input int idx, input int at_cyc);
    exp_t e;
    e.idx = idx;
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input int len, input logic dir);
    req_len[i*W +: W] = W'(len);
    req_dir[i]        = dir;
    req[i]            = 1'b1;
  endtask

  // Advance to the falling edge in cycle c.
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done !== '0) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got %b expected none (cycle %0d)", done, cyc);
      end else begin
        e = sb.pop_front();
        chk("done_vec", done, oh(e.idx));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    req_dir = '0;
    pause   = 1'b0;
    abort   = 1'b0;
    at(2);
    reset = 1'b0;
    at(3);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_tercnt", tercnt, 1);

    // single up interval, len 5
    t0 = cyc;
    set_req(0, 5, 1'b1);
    expect_done(0, t0 + 8);
    at(t0 + 1);
    chk("s1_gnt", gnt, 4'b0001);
    chk("s1_busy", busy, 1);
    for (int k = 0; k <= 5; k++) begin
      at(t0 + 2 + k);
      chk("s1_count", count, k);
    end
    chk("s1_tercnt", tercnt, 1);
    at(t0 + 8);
    req[0] = 1'b0;
    at(t0 + 9);
    chk("s1_busy_end", busy, 0);
    chk("s1_gnt_end", gnt, 0);

    // down interval with len 0
    t0 = cyc;
    set_req(2, 0, 1'b0);
    expect_done(2, t0 + 3);
    at(t0 + 2);
    chk("s2_count", count, 0);
    chk("s2_tercnt", tercnt, 1);
    chk("s2_gnt", gnt, 4'b0100);
    at(t0 + 3);
    req[2] = 1'b0;
    at(t0 + 4);

    // reset pulse so the pointer starts at 0 for round-robin
    reset = 1'b1;
    at(cyc + 1);
    reset = 1'b0;
    chk("rst2_busy", busy, 0);

    // round-robin with all four requests held, len 1
    t0 = cyc;
    for (int i = 0; i < N; i++) set_req(i, 1, 1'b1);
    for (int k = 0; k < 5; k++) expect_done(k % 4, t0 + 4 + 5 * k);
    for (int k = 0; k < 5; k++) begin
      at(t0 + 1 + 5 * k);
      chk("rr_gnt", gnt, oh(k % 4));
      at(t0 + 4 + 5 * k);
      if (k == 4) req = '0;
      at(t0 + 5 + 5 * k);
      chk("rr_idle_gnt", gnt, 0);
      chk("rr_idle_busy", busy, 0);
    end

    // pause for two cycles while count is 1
    t0 = cyc;
    set_req(1, 3, 1'b1);
    expect_done(1, t0 + 8);
    at(t0 + 3);
    chk("p_count_a", count, 1);
    pause = 1'b1;
    at(t0 + 4);
    chk("p_count_b", count, 1);
    at(t0 + 5);
    chk("p_count_c", count, 1);
    pause = 1'b0;
    at(t0 + 6);
    chk("p_count_d", count, 2);
    at(t0 + 8);
    req[1] = 1'b0;
    at(t0 + 9);

    // abort at count 4, pending req[0] granted next
    t0 = cyc;
    set_req(3, 10, 1'b1);
    set_req(0, 2, 1'b1);
    expect_done(0, t0 + 12);
    at(t0 + 1);
    chk("ab_gnt", gnt, 4'b1000);
    at(t0 + 6);
    chk("ab_count", count, 4);
    abort = 1'b1;
    at(t0 + 7);
    chk("ab_gnt_clr", gnt, 0);
    chk("ab_busy_clr", busy, 0);
    abort  = 1'b0;
    req[3] = 1'b0;
    at(t0 + 8);
    chk("ab_next_gnt", gnt, 4'b0001);
    at(t0 + 12);
    req[0] = 1'b0;
    at(t0 + 13);

    // abort coincident with terminal count
    t0 = cyc;
    set_req(1, 2, 1'b1);
    at(t0 + 4);
    chk("abt_tercnt", tercnt, 1);
    abort = 1'b1;
    at(t0 + 5);
    chk("abt_busy", busy, 0);
    chk("abt_gnt", gnt, 0);
    abort  = 1'b0;
    req[1] = 1'b0;
    at(t0 + 6);

    // pause coincident with terminal count
    t0 = cyc;
    set_req(2, 1, 1'b1);
    expect_done(2, t0 + 4);
    at(t0 + 3);
    chk("pt_tercnt", tercnt, 1);
    pause = 1'b1;
    at(t0 + 4);
    pause  = 1'b0;
    req[2] = 1'b0;
    at(t0 + 5);

    // reset mid-run, then pointer restarts at 0
    t0 = cyc;
    set_req(1, 6, 1'b1);
    at(t0 + 1);
    chk("rm_gnt", gnt, 4'b0010);
    at(t0 + 5);
    chk("rm_count", count, 3);
    reset = 1'b1;
    at(t0 + 6);
    chk("rm_count_rst", count, 0);
    chk("rm_gnt_rst", gnt, 0);
    chk("rm_busy_rst", busy, 0);
    reset = 1'b0;
    req   = '0;
    at(t0 + 7);
    t1 = cyc;
    set_req(0, 0, 1'b1);
    set_req(2, 1, 1'b1);
    expect_done(0, t1 + 3);
    expect_done(2, t1 + 8);
    at(t1 + 1);
    chk("rm_ptr_gnt", gnt, 4'b0001);
    at(t1 + 3);
    req[0] = 1'b0;
    at(t1 + 5);
    chk("rm_req2_gnt", gnt, 4'b0100);
    at(t1 + 8);
    req[2] = 1'b0;
    at(t1 + 12);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
